sram_packet_reader: RTL
=======================

# sram_packet_reader

Reads one stored packet out of a single SRAM bank by walking its page chain through the bank's read port (`rd_another_page`/`rd_page` in, `rd_xfer_data`/`rd_next_page`/`rd_ecc_code` back). It sits directly downstream of the SRAM interface, between the port scheduler that picks the next packet and the output port that consumes the half-word stream. It issues exactly one `rd_another_page` per page, so every page it reads is recycled into the bank's free list. It also forwards each page's ECC code and, at end of packet, the jump-table successor of the tail page, which is the next concatenated packet's head.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SRAM_IDX`  in  5  index of the bank this reader serves.
- `rd_start`  in  1  one-cycle read request.
- `rd_head_addr`  in  16  packet head as {bank[4:0], page[10:0]}.
- `rd_busy`  out  1  a packet is being read; `rd_start` is ignored while high.
- `rd_start_err`  out  1  one-cycle pulse: request rejected because the bank index mismatched.
- `rd_another_page`  out  1  to the SRAM interface; page switch and recycle.
- `rd_page`  out  11  to the SRAM interface; current page.
- `rd_xfer_data`  in  16  from the SRAM interface.
- `rd_next_page`  in  16  from the SRAM interface.
- `rd_ecc_code`  in  8  from the SRAM interface.
- `out_data_vld`  out  1  half-word valid.
- `out_data`  out  16  half-word.
- `out_start_of_packet`  out  1  high with half-word 0 (the header).
- `out_end_of_packet`  out  1  high with the last half-word.
- `out_ecc_vld`  out  1  high with half-word 0 of each page.
- `out_ecc_code`  out  8  ECC code of that page.
- `out_next_head_addr`  out  16  jump-table entry of the tail page; valid while `out_end_of_packet` is high.

## Operation
SRAM read-port contract:
- In cycle i, drive `rd_another_page`=1 and `rd_page`=P.
- Half-word k of page P appears on `rd_xfer_data` in cycle i+1+k, for k=0..7.
- `rd_next_page` and `rd_ecc_code` for P are valid from cycle i+1 for as long as `rd_page` holds P.
- `rd_page` is held at P from cycle i through cycle i+7.

States:
- IDLE: `rd_busy`=0. If `rd_start`=1 and `rd_head_addr[15:11]`==`SRAM_IDX`, latch the head page and go to ISSUE. On a bank-index mismatch, pulse `rd_start_err` and stay in IDLE.
- ISSUE (one cycle): register outputs `rd_another_page`=1 and `rd_page`=head page, then go to STREAM.
- STREAM:
  - A 3-bit half-word-in-page counter and a 9-bit received counter advance on every data cycle.
  - In the first data cycle, take L = `rd_xfer_data[15:7]` (total half-words including the header). L=0 is treated as 1.
  - Page count N = ceil(L/8), held in a 7-bit register (1..64).
  - In each page's first data cycle, capture `rd_next_page[10:0]` as the successor and `rd_ecc_code`.
  - In the page's 8th data cycle, if pages issued < N, drive `rd_another_page`=1 with `rd_page`=successor. Pages run back to back at 8 cycles per page.
  - When the received counter reaches L-1, go to IDLE. `rd_another_page` is never asserted for a page beyond the tail.
- Output register stage: every `out_*` signal is a registered copy of the corresponding `rd_xfer_data` cycle, with its flags.
- On the tail page, the captured full 16-bit `rd_next_page` drives `out_next_head_addr`.
- `rd_page` holds its last value in IDLE. `rd_another_page` is 0 outside the ISSUE and page-switch cycles.

## Timing
- Reset: all outputs 0, state IDLE, all counters 0. Reset asserted mid-packet aborts immediately, with no further `rd_another_page`; the remaining pages of that packet are not recycled.
- `rd_start` sampled at edge s:
  - `rd_another_page` high in cycle s+1;
  - header on `rd_xfer_data` in cycle s+2;
  - `out_start_of_packet`/`out_data_vld` in cycle s+3.
- Page j (0-based) is issued in cycle s+1+8j.
- `out_end_of_packet` occurs in cycle s+3+(L-1).
- `rd_busy` is high from s+1 through the cycle in which the last half-word is on `rd_xfer_data`. A new `rd_start` may arrive in the same cycle `out_end_of_packet` is high, giving a 2-cycle bubble between packets.
- Short packets:
  - L=1: `out_start_of_packet` and `out_end_of_packet` are high in the same cycle.
  - L a multiple of 8: the last page is fully consumed and no extra page is issued.
- `out_data_vld` has no gaps within a packet. There is no backpressure; the downstream side must accept one half-word per cycle.

## Test plan
- Single page: head 0x1805 with `SRAM_IDX`=3, header L=5. Expect one `rd_another_page` (`rd_page`=5), 5 outputs with SOP in cycle s+3 and EOP in cycle s+7, `rd_busy` low afterwards.
- Exact page: L=8. Expect exactly one page issued and EOP on the 8th half-word; no second `rd_another_page`.
- Chain: L=20 over pages 5→9→2. Expect issues at s+1, s+9 and s+17 with `rd_page` 5/9/2, three `out_ecc_vld` pulses carrying each page's code, 20 contiguous half-words, and `out_next_head_addr` equal to page 2's jump entry.
- Collisions: `rd_start` while busy is ignored. `rd_start` with `rd_head_addr[15:11]`≠`SRAM_IDX` gives one `rd_start_err` pulse and no `rd_another_page`. A back-to-back start in the EOP cycle issues in the next cycle.
- Reset: `rst_n` low during page 2 of an L=20 packet. Expect all outputs 0 asynchronously, and a clean read of a new L=3 packet after release.

Source files
------------

// File: rtl/sram_packet_reader.sv
// Single-bank packet reader: follows a packet's page chain through the SRAM read
// port, recycles each page once and streams the half-words with SOP/EOP/ECC flags.
module sram_packet_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  SRAM_IDX,
    input  logic        rd_start,
    input  logic [15:0] rd_head_addr,
    output logic        rd_busy,
    output logic        rd_start_err,
    output logic        rd_another_page,
    output logic [10:0] rd_page,
    input  logic [15:0] rd_xfer_data,
    input  logic [15:0] rd_next_page,
    input  logic [7:0]  rd_ecc_code,
    output logic        out_data_vld,
    output logic [15:0] out_data,
    output logic        out_start_of_packet,
    output logic        out_end_of_packet,
    output logic        out_ecc_vld,
    output logic [7:0]  out_ecc_code,
    output logic [15:0] out_next_head_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        err_q;
    logic        rap_q;
    logic [10:0] page_q;
    logic [2:0]  hw_q;
    logic [8:0]  rcv_q;
    logic [8:0]  len_q;
    logic [6:0]  npg_q;
    logic [6:0]  issued_q;
    logic [10:0] succ_q;
    logic [15:0] jump_q;

    logic        out_vld_q;
    logic [15:0] out_data_q;
    logic        out_sop_q;
    logic        out_eop_q;
    logic        out_eccv_q;
    logic [7:0]  out_ecc_q;
    logic [15:0] out_nh_q;

    logic [8:0]  hdr_len;
    logic [9:0]  hdr_sum;
    logic [8:0]  len_d;
    logic [6:0]  npg_d;
    logic [10:0] succ_d;
    logic [15:0] jump_d;
    logic        last_hw;
    logic        switch_pg;

    // Length and page count come straight off the bus in the header cycle, so the
    // first data cycle uses the live values and later cycles the registered ones.
    always_comb begin
        hdr_len   = (rd_xfer_data[15:7] == 9'd0) ? 9'd1 : rd_xfer_data[15:7];
        hdr_sum   = {1'b0, hdr_len} + 10'd7;
        len_d     = (rcv_q == 9'd0) ? hdr_len : len_q;
        npg_d     = (rcv_q == 9'd0) ? hdr_sum[9:3] : npg_q;
        succ_d    = (hw_q == 3'd0) ? rd_next_page[10:0] : succ_q;
        jump_d    = (hw_q == 3'd0) ? rd_next_page : jump_q;
        last_hw   = (rcv_q == (len_d - 9'd1));
        switch_pg = (hw_q == 3'd6) && (issued_q < npg_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rap_q      <= 1'b0;
            page_q     <= 11'd0;
            hw_q       <= 3'd0;
            rcv_q      <= 9'd0;
            len_q      <= 9'd0;
            npg_q      <= 7'd0;
            issued_q   <= 7'd0;
            succ_q     <= 11'd0;
            jump_q     <= 16'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= 16'd0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_eccv_q <= 1'b0;
            out_ecc_q  <= 8'd0;
            out_nh_q   <= 16'd0;
        end else begin
            rap_q      <= 1'b0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= 16'd0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_eccv_q <= 1'b0;
            out_ecc_q  <= 8'd0;
            out_nh_q   <= 16'd0;
            case (state_q)
                IDLE: begin
                    if (rd_start) begin
                        if (rd_head_addr[15:11] == SRAM_IDX) begin
                            rap_q   <= 1'b1;
                            page_q  <= rd_head_addr[10:0];
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    hw_q     <= 3'd0;
                    rcv_q    <= 9'd0;
                    issued_q <= 7'd1;
                    state_q  <= STREAM;
                end
                STREAM: begin
                    hw_q       <= hw_q + 3'd1;
                    rcv_q      <= rcv_q + 9'd1;
                    len_q      <= len_d;
                    npg_q      <= npg_d;
                    succ_q     <= succ_d;
                    jump_q     <= jump_d;
                    out_vld_q  <= 1'b1;
                    out_data_q <= rd_xfer_data;
                    out_sop_q  <= (rcv_q == 9'd0);
                    out_eop_q  <= last_hw;
                    out_eccv_q <= (hw_q == 3'd0);
                    out_ecc_q  <= (hw_q == 3'd0) ? rd_ecc_code : 8'd0;
                    out_nh_q   <= last_hw ? jump_d : 16'd0;
                    // Switch one cycle early so the next page's header lands right
                    // after this page's 8th half-word.
                    if (switch_pg && !last_hw) begin
                        rap_q    <= 1'b1;
                        page_q   <= succ_q;
                        issued_q <= issued_q + 7'd1;
                    end
                    if (last_hw) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_busy             = busy_q;
    assign rd_start_err        = err_q;
    assign rd_another_page     = rap_q;
    assign rd_page             = page_q;
    assign out_data_vld        = out_vld_q;
    assign out_data            = out_data_q;
    assign out_start_of_packet = out_sop_q;
    assign out_end_of_packet   = out_eop_q;
    assign out_ecc_vld         = out_eccv_q;
    assign out_ecc_code        = out_ecc_q;
    assign out_next_head_addr  = out_nh_q;

endmodule
